dataflow_stage_scheduler: RTL and testbench

- Sequences a chain of NUM_STAGES ap_ctrl_chain dataflow stages (the toy module_1..module_4 style kernels) over ITER iterations.
- Drives each stage's ap_start and ap_continue, and counts its ap_done pulses.
- Lets stages overlap across iterations, bounded by a run-ahead limit.
- Presents one ap_ctrl_chain handshake to the top level.

---
 rtl/dataflow_sched_pkg.sv | 10 +
 rtl/dataflow_stage_slot.sv | 50 +++++
 rtl/dataflow_stage_scheduler.sv | 91 +++++++++
 tb/tb_dataflow_stage_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_sched_pkg.sv
// dataflow_sched_pkg: shared types and constants for the dataflow stage scheduler.
package dataflow_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int ITER_W_DEF = 16;
  localparam int MAX_AHEAD_DEF = 2;
  function automatic int ahead_w(input int max_ahead);
    return $clog2(max_ahead + 1);
  endfunction
  localparam int AHEAD_W_DEF = ahead_w(MAX_AHEAD_DEF);
endpackage

// File: rtl/dataflow_stage_slot.sv
// dataflow_stage_slot: per-stage start/done bookkeeping and registered ap_start request.
module dataflow_stage_slot import dataflow_sched_pkg::*; #(
  parameter int ITER_W = ITER_W_DEF,
  parameter int MAX_AHEAD = MAX_AHEAD_DEF,
  parameter bit FIRST = 1'b0,
  parameter bit LAST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              run_i,
  input  logic [ITER_W-1:0] iters_i,
  input  logic [ITER_W-1:0] up_done_i,
  input  logic [ITER_W-1:0] dn_done_i,
  input  logic              ready_i,
  input  logic              done_i,
  output logic              start_o,
  output logic [ITER_W-1:0] start_cnt_o,
  output logic [ITER_W-1:0] done_cnt_o
);
  localparam int AW = ahead_w(MAX_AHEAD);
  logic [ITER_W-1:0] start_cnt_q, start_cnt_d, done_cnt_q, done_cnt_d, lead;
  logic req_q, req_d, src_ok, lead_ok, elig, start_inc, done_inc;
  always_comb begin
    lead = start_cnt_q - dn_done_i;
    src_ok = FIRST ? (start_cnt_q < iters_i) : (start_cnt_q < up_done_i);
    lead_ok = LAST || (((lead >> AW) == '0) && (lead[AW-1:0] < AW'(MAX_AHEAD)));
    elig = run_i && (start_cnt_q == done_cnt_q) && src_ok && lead_ok;
    start_inc = req_q & ready_i;
    done_inc = run_i & done_i & (start_cnt_q > done_cnt_q);
    start_cnt_d = clr_i ? '0 : start_cnt_q + ITER_W'(start_inc);
    done_cnt_d = clr_i ? '0 : done_cnt_q + ITER_W'(done_inc);
    // a raised request is held until accepted; eligibility only raises it
    req_d = ~clr_i & (req_q ? ~ready_i : elig);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_cnt_q <= '0;
      done_cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      start_cnt_q <= start_cnt_d;
      done_cnt_q <= done_cnt_d;
      req_q <= req_d;
    end
  end
  assign start_o = req_q;
  assign start_cnt_o = start_cnt_q;
  assign done_cnt_o = done_cnt_q;
endmodule

// File: rtl/dataflow_stage_scheduler.sv
// dataflow_stage_scheduler: runs a chain of ap_ctrl_chain stages for a number of iterations
// behind a single ap_ctrl_chain handshake, letting stages overlap up to MAX_AHEAD frames.
module dataflow_stage_scheduler import dataflow_sched_pkg::*; #(
  parameter int NUM_STAGES = 3,
  parameter int ITER_W = ITER_W_DEF,
  parameter int MAX_AHEAD = MAX_AHEAD_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic                  ap_continue,
  input  logic [ITER_W-1:0]     iter_count,
  output logic [NUM_STAGES-1:0] stg_start,
  input  logic [NUM_STAGES-1:0] stg_ready,
  input  logic [NUM_STAGES-1:0] stg_done,
  output logic [NUM_STAGES-1:0] stg_continue,
  output logic                  busy
);
  localparam int L = NUM_STAGES - 1;
  state_e state_q, state_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] start_cnt [NUM_STAGES];
  logic [ITER_W-1:0] done_cnt [NUM_STAGES];
  logic done_q, done_d, ready_q, ready_d, busy_q, busy_d, clr, run, last_hit;
  assign run = state_q == RUN;
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
    dataflow_stage_slot #(
      .ITER_W(ITER_W),
      .MAX_AHEAD(MAX_AHEAD),
      .FIRST(k == 0),
      .LAST(k == L)
    ) u_slot (
      .clk_i(ap_clk),
      .rst_ni(ap_rst_n),
      .clr_i(clr),
      .run_i(run),
      .iters_i(iters_q),
      .up_done_i(done_cnt[k == 0 ? 0 : k - 1]),
      .dn_done_i(done_cnt[k == L ? k : k + 1]),
      .ready_i(stg_ready[k]),
      .done_i(stg_done[k]),
      .start_o(stg_start[k]),
      .start_cnt_o(start_cnt[k]),
      .done_cnt_o(done_cnt[k])
    );
  end
  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    clr = 1'b0;
    last_hit = stg_done[L] & (start_cnt[L] != done_cnt[L]) & (done_cnt[L] + ITER_W'(1) == iters_q);
    done_d = (state_q == DONE) & ~(done_q & ap_continue);
    ready_d = run & stg_start[0] & stg_ready[0] & (start_cnt[0] + ITER_W'(1) == iters_q);
    busy_d = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) busy_d = busy_d | (start_cnt[i] != done_cnt[i]);
    unique case (state_q)
      IDLE: if (ap_start) begin
        iters_d = iter_count;
        clr = 1'b1;
        state_d = (iter_count == '0) ? DONE : RUN;
      end
      RUN: state_d = last_hit ? DONE : RUN;
      // leave only once the top level has seen ap_done
      DONE: state_d = (done_q & ap_continue) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      iters_q <= '0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iters_q <= iters_d;
      done_q <= done_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
  assign ap_done = done_q;
  assign ap_ready = ready_q;
  assign ap_idle = (state_q == IDLE) & ~ap_start;
  assign stg_continue = {NUM_STAGES{run}};
  assign busy = busy_q;
endmodule

// File: tb/tb_dataflow_stage_scheduler.sv
// tb_dataflow_stage_scheduler: directed bench with behavioural stage kernels and a run scoreboard.
module tb_dataflow_stage_scheduler;
  localparam int NS = 3, IW = 16, DLY = 3, LIMIT = 400, NOM_LAT = 37;
  typedef struct { int iters; int lat; } exp_t;
  logic ap_clk = 1'b0;
  logic ap_rst_n, ap_start, ap_continue, ap_done, ap_idle, ap_ready, busy, clr_model;
  logic [IW-1:0] iter_count;
  logic [NS-1:0] stg_start, stg_ready, stg_done, stg_continue, rdy_en, hold, spur, done_raw;
  int tmr [NS];
  int acc [NS];
  int dn [NS];
  int q_up [NS][$];
  int rdy_pulses, ord_err, n_chk, n_pass, cyc_n, t0;
  exp_t sb[$];

  always #5 ap_clk = ~ap_clk;
  assign stg_ready = rdy_en;
  assign stg_done = (done_raw & ~hold) | spur;

  dataflow_stage_scheduler #(.NUM_STAGES(NS), .ITER_W(IW), .MAX_AHEAD(2)) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ap_ready(ap_ready),
    .ap_continue(ap_continue),
    .iter_count(iter_count),
    .stg_start(stg_start),
    .stg_ready(stg_ready),
    .stg_done(stg_done),
    .stg_continue(stg_continue),
    .busy(busy)
  );

  // stage kernels: done 3 edges after an accepted start; stage k iteration j
  // must be preceded by stage k-1 done j (tracked through q_up)
  always @(posedge ap_clk) begin
    bit fin [NS];
    if (!ap_rst_n) begin
      for (int k = 0; k < NS; k++) tmr[k] = 0;
    end else if (clr_model) begin
      for (int k = 0; k < NS; k++) begin
        acc[k] = 0;
        dn[k] = 0;
        q_up[k].delete();
      end
      rdy_pulses = 0;
      ord_err = 0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        fin[k] = stg_done[k] && tmr[k] == 1;
        if (fin[k]) begin
          tmr[k] = 0;
          dn[k]++;
        end else if (tmr[k] > 1) tmr[k]--;
      end
      for (int k = 0; k < NS; k++) begin
        if (stg_start[k] && stg_ready[k]) begin
          if (k > 0) begin
            if (q_up[k].size() == 0) ord_err++;
            else if (q_up[k].pop_front() != acc[k]) ord_err++;
          end
          acc[k]++;
          tmr[k] = DLY;
        end
      end
      for (int k = 0; k < NS - 1; k++) if (fin[k]) q_up[k + 1].push_back(dn[k] - 1);
      if (ap_ready) rdy_pulses++;
    end
    #1;
    for (int k = 0; k < NS; k++) done_raw[k] = tmr[k] == 1;
  end

  task automatic cyc();
    @(posedge ap_clk);
    @(negedge ap_clk);
    cyc_n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic launch(input int iters, input int lat);
    sb.push_back('{iters, lat});
    clr_model = 1'b1;
    iter_count = IW'(iters);
    ap_start = 1'b1;
    t0 = cyc_n;
    cyc();
    clr_model = 1'b0;
    ap_start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    exp_t e;
    int n = 0;
    while (ap_done !== 1'b1 && n < LIMIT) begin
      cyc();
      n++;
    end
    check({tag, "_done"}, 32'(ap_done), 1);
    e = sb.pop_front();
    if (e.lat >= 0) check({tag, "_lat"}, cyc_n - t0, e.lat);
    for (int k = 0; k < NS; k++) begin
      check($sformatf("%s_acc%0d", tag, k), acc[k], e.iters);
      check($sformatf("%s_dn%0d", tag, k), dn[k], e.iters);
    end
    check({tag, "_ready"}, rdy_pulses, 32'(e.iters > 0));
    check({tag, "_order"}, ord_err, 0);
    ap_continue = 1'b1;
    cyc();
    ap_continue = 1'b0;
    check({tag, "_clear"}, 32'(ap_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_chk = 0; n_pass = 0; cyc_n = 0; t0 = 0;
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; iter_count = '0;
    rdy_en = '1; hold = '0; spur = '0; clr_model = 1'b0;
    repeat (3) cyc();
    check("rst_start", 32'(stg_start), 0);
    check("rst_cont", 32'(stg_continue), 0);
    check("rst_done", 32'(ap_done), 0);
    check("rst_ready", 32'(ap_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_idle", 32'(ap_idle), 1);
    ap_rst_n = 1'b1;
    cyc();

    iter_count = '0;
    ap_start = 1'b1;
    cyc();
    ap_start = 1'b0;
    check("zero_done_d1", 32'(ap_done), 0);
    cyc();
    check("zero_done_d2", 32'(ap_done), 1);
    check("zero_idle", 32'(ap_idle), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("zero_hold%0d", i), 32'(ap_done), 1);
      check($sformatf("zero_nostart%0d", i), 32'(stg_start), 0);
    end
    ap_continue = 1'b1;
    cyc();
    ap_continue = 1'b0;
    check("zero_clear", 32'(ap_done), 0);
    check("zero_back_idle", 32'(ap_idle), 1);

    spur[1] = 1'b1;
    cyc();
    spur[1] = 1'b0;
    launch(5, NOM_LAT);
    cyc();
    spur[1] = 1'b1;
    cyc();
    spur[1] = 1'b0;
    check("nom_cont", 32'(stg_continue), 7);
    check("nom_idle", 32'(ap_idle), 0);
    repeat (8) cyc();
    check("nom_busy", 32'(busy), 1);
    finish_run("nom");
    check("nom_busy_end", 32'(busy), 0);

    rdy_en[0] = 1'b0;
    launch(3, -1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("held_req%0d", i), 32'(stg_start[0]), 1);
      check($sformatf("held_cnt%0d", i), acc[0], 0);
      cyc();
    end
    rdy_en[0] = 1'b1;
    cyc();
    check("held_acc", acc[0], 1);
    check("held_drop", 32'(stg_start[0]), 0);
    finish_run("held");

    hold[2] = 1'b1;
    launch(5, -1);
    repeat (40) cyc();
    check("bp_acc0", acc[0], 4);
    check("bp_acc1", acc[1], 2);
    check("bp_acc2", acc[2], 1);
    check("bp_stall", 32'(stg_start[1]), 0);
    hold[2] = 1'b0;
    n = 0;
    while (!stg_start[1] && n < 6) begin
      cyc();
      n++;
    end
    check("bp_resume", n, 2);
    finish_run("bp");

    launch(5, -1);
    n = 0;
    while (acc[1] < 2 && n < LIMIT) begin
      cyc();
      n++;
    end
    check("mrst_reach", acc[1], 2);
    ap_rst_n = 1'b0;
    cyc();
    sb.delete();
    check("mrst_start", 32'(stg_start), 0);
    check("mrst_done", 32'(ap_done), 0);
    check("mrst_idle", 32'(ap_idle), 1);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_cont", 32'(stg_continue), 0);
    ap_rst_n = 1'b1;
    repeat (3) cyc();
    check("mrst_nodone", 32'(ap_done), 0);
    launch(5, NOM_LAT);
    finish_run("fresh");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
